// File: rtl/cnt_pkg.sv
// Shared definitions for the round-robin counter-sharing arbiter.
// Holds the default sizes and the FSM state encoding.
package cnt_pkg;

    localparam int NREQ_DEF = 2;
    localparam int W_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cnt_core.sv
// W-bit synchronous up-counter shared by all requesters.
// A synchronous clear takes priority over the count enable.
module cnt_core #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/cnt_share_arb.sv
// Round-robin arbiter that lends one shared counter to NREQ requesters.
// A grant runs len+1 counting cycles, then pulses done for one cycle.
module cnt_share_arb
    import cnt_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ*W-1:0] len,
    input  logic            abort,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic [NREQ-1:0] done,
    output logic [W-1:0]    cnt_q
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [W-1:0]    len_q, len_d;

    logic [PW-1:0]   win;
    logic [PW-1:0]   ptrNext;
    logic [NREQ-1:0] winOneHot;
    logic [W-1:0]    winLen;
    logic            atTerm;
    logic            cntClr;
    logic            cntEn;

    // Pass one looks at bits at or above the pointer; pass two wraps to the lowest set bit.
    always_comb begin
        logic found;
        win   = '0;
        found = 1'b0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req[j] && (j >= int'(ptr_q))) begin
                win   = PW'(j);
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int j = NREQ - 1; j >= 0; j--) begin
                if (req[j]) begin
                    win = PW'(j);
                end
            end
        end
    end

    always_comb begin
        winOneHot = '0;
        winLen    = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (int'(win) == j) begin
                winOneHot[j] = 1'b1;
                winLen       = len[j*W +: W];
            end
        end
    end

    assign ptrNext = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
    assign atTerm  = (cnt_q == len_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        ptr_d   = ptr_q;
        len_d   = len_q;
        cntClr  = 1'b1;
        cntEn   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = RUN;
                    gnt_d   = winOneHot;
                    ptr_d   = ptrNext;
                    len_d   = winLen;
                end
            end
            // Abort outranks reaching the terminal count, so no done pulse is issued.
            RUN: begin
                cntClr = abort;
                if (abort) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (atTerm) begin
                    state_d = DONE;
                    done_d  = gnt_q;
                end else begin
                    cntEn = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
        end
    end

    cnt_core #(.W(W)) u_cnt_core (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cntClr),
        .en      (cntEn),
        .q       (cnt_q)
    );

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_cnt_share_arb.sv
// Directed self-checking bench for cnt_share_arb with NREQ=2, W=4.
// A vector table covers the basic sequences; hand-written sequences cover abort and reset corners.
module tb_cnt_share_arb;

    logic       clk;
    logic       reset_n;
    logic [1:0] req;
    logic [7:0] len;
    logic       abort;
    logic [1:0] gnt;
    logic       busy;
    logic [1:0] done;
    logic [3:0] cnt_q;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [7:0] len;
        logic       abort;
        logic [1:0] gnt;
        logic       busy;
        logic [1:0] done;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[$];

    cnt_share_arb #(.NREQ(2), .W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .len     (len),
        .abort   (abort),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .cnt_q   (cnt_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not reach the summary");
        $fatal(1, "[TB] timeout");
    end

    task automatic applyStimulus(input logic [1:0] r, input logic [7:0] l, input logic a);
        req   = r;
        len   = l;
        abort = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] eg, input logic eb,
                               input logic [1:0] ed, input logic [3:0] ec);
        assertCount++;
        if ({gnt, busy, done, cnt_q} !== {eg, eb, ed, ec}) begin
            failCount++;
            $display("[TB] FAIL %s: got gnt=%b busy=%b done=%b cnt=%0d, expected gnt=%b busy=%b done=%b cnt=%0d",
                     name, gnt, busy, done, cnt_q, eg, eb, ed, ec);
        end
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        applyStimulus(2'b00, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        // Basic grant, alternation and zero-length vectors; rst pulses reset before the row.
        vecs.push_back('{1'b1, 2'b01, 8'h03, 1'b0, 2'b01, 1'b1, 2'b00, 4'd0});
        vecs.push_back('{1'b0, 2'b00, 8'h0F, 1'b0, 2'b01, 1'b1, 2'b00, 4'd1});
        vecs.push_back('{1'b0, 2'b00, 8'h0F, 1'b0, 2'b01, 1'b1, 2'b00, 4'd2});
        vecs.push_back('{1'b0, 2'b00, 8'h0F, 1'b0, 2'b01, 1'b1, 2'b00, 4'd3});
        vecs.push_back('{1'b0, 2'b00, 8'h0F, 1'b0, 2'b01, 1'b1, 2'b01, 4'd3});
        vecs.push_back('{1'b0, 2'b00, 8'h0F, 1'b0, 2'b00, 1'b0, 2'b00, 4'd0});
        vecs.push_back('{1'b1, 2'b11, 8'h21, 1'b0, 2'b01, 1'b1, 2'b00, 4'd0});
        vecs.push_back('{1'b0, 2'b11, 8'h21, 1'b0, 2'b01, 1'b1, 2'b00, 4'd1});
        vecs.push_back('{1'b0, 2'b11, 8'h21, 1'b0, 2'b01, 1'b1, 2'b01, 4'd1});
        vecs.push_back('{1'b0, 2'b11, 8'h21, 1'b0, 2'b00, 1'b0, 2'b00, 4'd0});
        vecs.push_back('{1'b0, 2'b11, 8'h21, 1'b0, 2'b10, 1'b1, 2'b00, 4'd0});
        vecs.push_back('{1'b0, 2'b11, 8'h21, 1'b0, 2'b10, 1'b1, 2'b00, 4'd1});
        vecs.push_back('{1'b0, 2'b11, 8'h21, 1'b0, 2'b10, 1'b1, 2'b00, 4'd2});
        vecs.push_back('{1'b0, 2'b11, 8'h21, 1'b0, 2'b10, 1'b1, 2'b10, 4'd2});
        vecs.push_back('{1'b0, 2'b11, 8'h21, 1'b0, 2'b00, 1'b0, 2'b00, 4'd0});
        vecs.push_back('{1'b0, 2'b11, 8'h21, 1'b0, 2'b01, 1'b1, 2'b00, 4'd0});
        vecs.push_back('{1'b1, 2'b01, 8'h00, 1'b0, 2'b01, 1'b1, 2'b00, 4'd0});
        vecs.push_back('{1'b0, 2'b00, 8'h00, 1'b0, 2'b01, 1'b1, 2'b01, 4'd0});
        vecs.push_back('{1'b0, 2'b00, 8'h00, 1'b0, 2'b00, 1'b0, 2'b00, 4'd0});

        // Reset with both requests high must hold everything at zero.
        reset_n = 1'b0;
        applyStimulus(2'b11, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 2'b00, 1'b0, 2'b00, 4'd0);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) doReset();
            applyStimulus(vecs[i].req, vecs[i].len, vecs[i].abort);
            step();
            checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].busy, vecs[i].done, vecs[i].cnt);
        end

        // Maximum length walks the full counter range without wrapping.
        doReset();
        applyStimulus(2'b01, 8'h0F, 1'b0);
        step();
        checkOutput("len15_e0", 2'b01, 1'b1, 2'b00, 4'd0);
        req = 2'b00;
        for (int k = 1; k <= 15; k++) begin
            step();
            checkOutput($sformatf("len15_e%0d", k), 2'b01, 1'b1, 2'b00, 4'(k));
        end
        step();
        checkOutput("len15_done", 2'b01, 1'b1, 2'b01, 4'd15);
        step();
        checkOutput("len15_idle", 2'b00, 1'b0, 2'b00, 4'd0);

        // Abort mid-run: no done, and the pointer has already moved to requester 1.
        doReset();
        applyStimulus(2'b11, 8'h15, 1'b0);
        step();
        checkOutput("abort_e0", 2'b01, 1'b1, 2'b00, 4'd0);
        step();
        step();
        checkOutput("abort_e2", 2'b01, 1'b1, 2'b00, 4'd2);
        abort = 1'b1;
        step();
        checkOutput("abort_cut", 2'b00, 1'b0, 2'b00, 4'd0);
        abort = 1'b0;
        step();
        checkOutput("abort_next", 2'b10, 1'b1, 2'b00, 4'd0);
        step();
        step();
        checkOutput("abort_next_done", 2'b10, 1'b1, 2'b10, 4'd1);
        req = 2'b00;
        step();
        checkOutput("abort_next_idle", 2'b00, 1'b0, 2'b00, 4'd0);

        // Abort on the terminal-count cycle beats done; abort while idle is ignored.
        doReset();
        applyStimulus(2'b01, 8'h02, 1'b0);
        step();
        req = 2'b00;
        step();
        step();
        checkOutput("termabort_e2", 2'b01, 1'b1, 2'b00, 4'd2);
        abort = 1'b1;
        step();
        checkOutput("termabort_cut", 2'b00, 1'b0, 2'b00, 4'd0);
        step();
        checkOutput("termabort_nodone", 2'b00, 1'b0, 2'b00, 4'd0);
        req = 2'b01;
        step();
        checkOutput("idle_abort_grant", 2'b01, 1'b1, 2'b00, 4'd0);
        applyStimulus(2'b00, 8'h02, 1'b0);
        step();
        checkOutput("idle_abort_run", 2'b01, 1'b1, 2'b00, 4'd1);

        // Asynchronous reset mid-run clears outputs before any clock edge.
        doReset();
        applyStimulus(2'b01, 8'h0F, 1'b0);
        step();
        req = 2'b00;
        repeat (7) step();
        checkOutput("midrst_before", 2'b01, 1'b1, 2'b00, 4'd7);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_async", 2'b00, 1'b0, 2'b00, 4'd0);
        req = 2'b11;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        checkOutput("midrst_regrant", 2'b01, 1'b1, 2'b00, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
